// File: rtl/player_move_ctrl_pkg.sv
// Shared maze constants, direction/FSM encodings and the corner-offset helper
// used by the player movement sequencer.
package player_move_ctrl_pkg;

    localparam int MAP_WIDTH = 30;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TICK = 3'd1;
    localparam logic [2:0] ST_CALC      = 3'd2;
    localparam logic [2:0] ST_CHK_A     = 3'd3;
    localparam logic [2:0] ST_CHK_B     = 3'd4;
    localparam logic [2:0] ST_COMMIT    = 3'd5;

    // {add_edge_x, add_edge_y} for the leading corner A (second=0) or B (second=1).
    function automatic logic [1:0] corner_off(input logic [1:0] d, input logic second);
        case (d)
            DIR_UP:   corner_off = second ? 2'b10 : 2'b00;
            DIR_DOWN: corner_off = second ? 2'b11 : 2'b01;
            DIR_LEFT: corner_off = second ? 2'b01 : 2'b00;
            default:  corner_off = second ? 2'b11 : 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/player_move_ctrl_tick_gen.sv
// Free-running move-rate divider: one-cycle tick every MOVE_DIV clocks.
module player_move_ctrl_tick_gen #(
    parameter int MOVE_DIV = 416667
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement sequencer: throttles direction commands to the move tick and
// checks the two leading corners of the destination box against the tile map.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int CELL_SIZE   = 16,
    parameter int MAP_COLS    = MAP_WIDTH,
    parameter int MAP_ROWS    = 12,
    parameter int PLAYER_SIZE = 8,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 416667,
    parameter int START_X     = 16,
    parameter int START_Y     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dir_valid,
    input  logic [1:0]          dir,
    output logic                dir_ready,
    output logic [3:0]          map_row_addr,
    input  logic [MAP_COLS-1:0] map_row_bits,
    output logic [9:0]          pos_x,
    output logic [8:0]          pos_y,
    output logic                moved,
    output logic                blocked,
    output logic                busy
);

    localparam int X_MAX = MAP_COLS * CELL_SIZE - PLAYER_SIZE;
    localparam int Y_MAX = MAP_ROWS * CELL_SIZE - PLAYER_SIZE;
    localparam int EDGE  = PLAYER_SIZE - 1;

    logic       tick;
    logic [2:0] state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [9:0] pos_x_q, pos_x_d, nx_q, nx_d;
    logic [8:0] pos_y_q, pos_y_d, ny_q, ny_d;
    logic       reject_q, reject_d;
    logic       wall_a_q, wall_a_d;
    logic       wall_b_q, wall_b_d;
    logic       moved_q, moved_d;
    logic       blocked_q, blocked_d;

    // One extra sign bit on the candidate so a step below 0 shows up as bit 10/9.
    logic [10:0] cand_x;
    logic [9:0]  cand_y;
    logic        oob;

    logic [1:0] off;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [3:0] row;
    logic [4:0] col;
    logic       corner_wall;

    player_move_ctrl_tick_gen #(.MOVE_DIV(MOVE_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        cand_x = {1'b0, pos_x_q};
        cand_y = {1'b0, pos_y_q};
        case (dir_q)
            DIR_UP:   cand_y = {1'b0, pos_y_q} - 10'(STEP);
            DIR_DOWN: cand_y = {1'b0, pos_y_q} + 10'(STEP);
            DIR_LEFT: cand_x = {1'b0, pos_x_q} - 11'(STEP);
            default:  cand_x = {1'b0, pos_x_q} + 11'(STEP);
        endcase
        oob = cand_x[10] || cand_y[9] || (cand_x > 11'(X_MAX)) || (cand_y > 10'(Y_MAX));
    end

    always_comb begin
        off          = corner_off(dir_q, state_q == ST_CHK_B);
        cx           = nx_q + (off[1] ? 10'(EDGE) : 10'd0);
        cy           = ny_q + (off[0] ? 9'(EDGE) : 9'd0);
        row          = 4'(cy / 9'(CELL_SIZE));
        col          = 5'(cx / 10'(CELL_SIZE));
        corner_wall  = map_row_bits[5'(MAP_COLS - 1) - col];
        map_row_addr = (state_q == ST_CHK_A || state_q == ST_CHK_B) ? row : 4'd0;
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        reject_d  = reject_q;
        wall_a_d  = wall_a_q;
        wall_b_d  = wall_b_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dir_valid) begin
                    dir_d   = dir;
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (tick) state_d = ST_CALC;
            end
            ST_CALC: begin
                nx_d     = cand_x[9:0];
                ny_d     = cand_y[8:0];
                reject_d = oob;
                wall_a_d = 1'b0;
                wall_b_d = 1'b0;
                state_d  = oob ? ST_COMMIT : ST_CHK_A;
            end
            ST_CHK_A: begin
                wall_a_d = corner_wall;
                state_d  = ST_CHK_B;
            end
            ST_CHK_B: begin
                wall_b_d = corner_wall;
                state_d  = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!reject_q && !wall_a_q && !wall_b_q) begin
                    pos_x_d = nx_q;
                    pos_y_d = ny_q;
                    moved_d = 1'b1;
                end else begin
                    blocked_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            nx_q      <= '0;
            ny_q      <= '0;
            reject_q  <= 1'b0;
            wall_a_q  <= 1'b0;
            wall_b_q  <= 1'b0;
            pos_x_q   <= 10'(START_X);
            pos_y_q   <= 9'(START_Y);
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            reject_q  <= reject_d;
            wall_a_q  <= wall_a_d;
            wall_b_q  <= wall_b_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign dir_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign moved     = moved_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: three instances (open area, inner wall, left edge)
// on a bordered 30x12 map with one inner wall tile at row 4, col 7.
module tb_player_move_ctrl;
    import player_move_ctrl_pkg::*;

    typedef struct {
        logic [1:0] d;
        bit         mv;
        int         x;
        int         y;
    } vec_t;

    typedef struct {
        bit mv;
        int x;
        int y;
        int lat;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       dv [3];
    logic [1:0] dr [3];
    wire        rdy [3];
    wire        mv [3];
    wire        bl [3];
    wire        bsy [3];
    wire [3:0]  addr [3];
    wire [29:0] mrb [3];
    wire [9:0]  px [3];
    wire [8:0]  py [3];

    int   tcnt;
    int   cyc;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   sx [3] = '{16, 104, 0};
    int   sy [3] = '{16, 64, 16};
    exp_t exp_q [$];
    vec_t tbl [7];

    function automatic logic [29:0] map_row(input logic [3:0] r);
        logic [29:0] b;
        if (r == 4'd0 || r >= 4'd11) begin
            b = '1;
        end else begin
            b     = '0;
            b[29] = 1'b1;
            b[0]  = 1'b1;
            if (r == 4'd4) b[29-7] = 1'b1;
        end
        return b;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_map
        assign mrb[g] = map_row(addr[g]);
    end

    player_move_ctrl #(.MOVE_DIV(4)) u_dut0 (
        .clk(clk), .reset(reset), .dir_valid(dv[0]), .dir(dr[0]), .dir_ready(rdy[0]),
        .map_row_addr(addr[0]), .map_row_bits(mrb[0]), .pos_x(px[0]), .pos_y(py[0]),
        .moved(mv[0]), .blocked(bl[0]), .busy(bsy[0])
    );

    player_move_ctrl #(.MOVE_DIV(4), .START_X(104), .START_Y(64)) u_dut1 (
        .clk(clk), .reset(reset), .dir_valid(dv[1]), .dir(dr[1]), .dir_ready(rdy[1]),
        .map_row_addr(addr[1]), .map_row_bits(mrb[1]), .pos_x(px[1]), .pos_y(py[1]),
        .moved(mv[1]), .blocked(bl[1]), .busy(bsy[1])
    );

    player_move_ctrl #(.MOVE_DIV(4), .START_X(0), .START_Y(16)) u_dut2 (
        .clk(clk), .reset(reset), .dir_valid(dv[2]), .dir(dr[2]), .dir_ready(rdy[2]),
        .map_row_addr(addr[2]), .map_row_bits(mrb[2]), .pos_x(px[2]), .pos_y(py[2]),
        .moved(mv[2]), .blocked(bl[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tick phase and cycle index, both restarted by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= 0;
            cyc  <= 0;
        end else begin
            tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
            cyc  <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        total_cnt++;
        if (act == want) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, want);
    endtask

    task automatic run_cmd(input int k, input logic [1:0] d, input exp_t e);
        int   n;
        int   t_tick;
        bit   got;
        bit   addr_ok;
        exp_t x;
        @(negedge clk);
        dv[k] = 1'b1;
        dr[k] = d;
        n = 0;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", int'(rdy[k]), 1);
        exp_q.push_back(e);
        @(negedge clk);
        dv[k] = 1'b0;
        dr[k] = ~d;
        chk("busy_in_flight", int'(bsy[k] && !rdy[k]), 1);
        t_tick  = -1;
        got     = 1'b0;
        addr_ok = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            if (t_tick < 0 && tcnt == 3) t_tick = cyc;
            if (addr[k] != 4'd0) addr_ok = 1'b0;
            if (mv[k] || bl[k]) got = 1'b1;
            else @(negedge clk);
        end
        x = exp_q.pop_front();
        chk("pulse_seen", int'(got), 1);
        if (got) begin
            chk("moved", int'(mv[k]), int'(x.mv));
            chk("blocked", int'(bl[k]), int'(!x.mv));
            chk("pos_x", int'(px[k]), x.x);
            chk("pos_y", int'(py[k]), x.y);
            chk("latency", cyc - t_tick, x.lat);
            chk("ready_at_pulse", int'(rdy[k]), 1);
        end
        if (k == 2) chk("addr_zero_oob", int'(addr_ok), 1);
        @(negedge clk);
        chk("pulse_one_cycle", int'(mv[k] || bl[k]), 0);
    endtask

    initial begin
        exp_t e;
        int   t_tick;
        int   npulse;
        int   nbl;
        int   exp_y;
        int   last_p;
        bit   ok_rdy;
        bit   stray;

        tbl[0] = '{DIR_RIGHT, 1'b1, 17, 16};
        tbl[1] = '{DIR_UP,    1'b0, 17, 16};
        tbl[2] = '{DIR_LEFT,  1'b1, 16, 16};
        tbl[3] = '{DIR_LEFT,  1'b0, 16, 16};
        tbl[4] = '{DIR_DOWN,  1'b1, 16, 17};
        tbl[5] = '{DIR_DOWN,  1'b1, 16, 18};
        tbl[6] = '{DIR_RIGHT, 1'b1, 17, 18};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0;
            dr[k] = 2'b00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_pos_x", int'(px[k]), sx[k]);
            chk("rst_pos_y", int'(py[k]), sy[k]);
            chk("rst_moved", int'(mv[k]), 0);
            chk("rst_blocked", int'(bl[k]), 0);
            chk("rst_busy", int'(bsy[k]), 0);
            chk("rst_ready", int'(rdy[k]), 1);
            chk("rst_addr", int'(addr[k]), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            e.mv  = tbl[i].mv;
            e.x   = tbl[i].x;
            e.y   = tbl[i].y;
            e.lat = 5;
            run_cmd(0, tbl[i].d, e);
        end

        // Inner wall to the right, and a left step off the maze edge.
        e = '{1'b0, 104, 64, 5};
        run_cmd(1, DIR_RIGHT, e);
        e = '{1'b0, 0, 16, 3};
        run_cmd(2, DIR_LEFT, e);

        // Reset during CHK_A of a right step from (17,18).
        @(negedge clk);
        dv[0] = 1'b1;
        dr[0] = DIR_RIGHT;
        @(negedge clk);
        dv[0] = 1'b0;
        t_tick = -1;
        for (int c = 0; c < 20 && t_tick < 0; c++) begin
            if (tcnt == 3) t_tick = cyc;
            else @(negedge clk);
        end
        chk("mid_rst_tick_seen", int'(t_tick >= 0), 1);
        repeat (2) @(negedge clk);
        chk("chk_a_row_addr", int'(addr[0]), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pos_x", int'(px[0]), 16);
        chk("mid_rst_pos_y", int'(py[0]), 16);
        chk("mid_rst_moved", int'(mv[0]), 0);
        chk("mid_rst_blocked", int'(bl[0]), 0);
        chk("mid_rst_ready", int'(rdy[0]), 1);
        chk("mid_rst_addr", int'(addr[0]), 0);
        reset = 1'b0;
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mv[0] || bl[0] || bsy[0]) stray = 1'b1;
        end
        chk("mid_rst_no_pulse", int'(stray), 0);

        // dir_valid held high: one step per accepted tick, 8 cycles apart at MOVE_DIV=4.
        @(negedge clk);
        dv[0]  = 1'b1;
        dr[0]  = DIR_DOWN;
        exp_y  = 17;
        npulse = 0;
        nbl    = 0;
        ok_rdy = 1'b1;
        last_p = -1;
        for (int c = 0; c < 80 && npulse < 2; c++) begin
            if (rdy[0] == bsy[0]) ok_rdy = 1'b0;
            if (bl[0]) nbl++;
            if (mv[0]) begin
                chk("throttle_pos_y", int'(py[0]), exp_y);
                if (last_p >= 0) chk("throttle_period", cyc - last_p, 8);
                last_p = cyc;
                exp_y++;
                npulse++;
                if (npulse == 2) dv[0] = 1'b0;
            end
            if (npulse < 2) @(negedge clk);
        end
        chk("throttle_moves", npulse, 2);
        chk("throttle_ready_vs_busy", int'(ok_rdy), 1);
        chk("throttle_no_block", nbl, 0);
        repeat (10) @(negedge clk);
        chk("throttle_final_y", int'(py[0]), 18);
        chk("throttle_idle", int'(bsy[0]), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequences player movement against the 30×12 maze tile map. It accepts direction commands from the PS2 decode path and throttles them to a fixed move rate. For each command it checks the two leading corners of the player's destination box against the shared map row lookup, then commits or rejects the step. Its position outputs feed the VGA sprite overlay, and its row-address output drives the map ROM.

## Interface
Parameters:
- CELL_SIZE, 16: tile edge in pixels.
- MAP_COLS, 30: tiles per row; equals `MAP_WIDTH.
- MAP_ROWS, 12: tile rows.
- PLAYER_SIZE, 8: player box edge in pixels.
- STEP, 1: pixels moved per accepted command.
- MOVE_DIV, 416667: clock cycles per move tick (120 Hz at 50 MHz).
- START_X, 16: maze-relative reset X.
- START_Y, 16: maze-relative reset Y.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high.
- dir_valid  in  1  direction command present.
- dir  in  2  00 up, 01 down, 10 left, 11 right.
- dir_ready  out  1  command accepted when dir_valid && dir_ready.
- map_row_addr  out  4  row index to the map ROM.
- map_row_bits  in  30  row data, combinational, valid in the same cycle.
- pos_x  out  10  player top-left X, maze-relative pixels.
- pos_y  out  9  player top-left Y, maze-relative pixels.
- moved  out  1  one-cycle pulse on a committed step.
- blocked  out  1  one-cycle pulse on a rejected step.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Tile lookup for pixel (px,py): row = py/CELL_SIZE, col = px/CELL_SIZE. The tile is a wall when map_row_bits[MAP_COLS-1-col] is 1.
- FSM states: IDLE, WAIT_TICK, CALC, CHK_A, CHK_B, COMMIT.
- IDLE: dir_ready=1. On handshake, latch dir and go to WAIT_TICK.
- WAIT_TICK: hold until the tick pulse, then go to CALC.
- CALC: compute the candidate (nx,ny) from pos ± STEP along dir.
  - If the candidate lies outside 0..MAP_COLS*CELL_SIZE-PLAYER_SIZE in X or 0..MAP_ROWS*CELL_SIZE-PLAYER_SIZE in Y, set reject and go straight to COMMIT with no lookups.
  - Underflow is detected with one extra sign bit.
  - Otherwise go to CHK_A.
- Corner pairs, A then B, with E = PLAYER_SIZE-1:
  - up: (nx,ny), (nx+E,ny)
  - down: (nx,ny+E), (nx+E,ny+E)
  - left: (nx,ny), (nx,ny+E)
  - right: (nx+E,ny), (nx+E,ny+E)
- CHK_A: drive map_row_addr for corner A and register that corner's wall bit. Go to CHK_B.
- CHK_B: same for corner B. Go to COMMIT.
- COMMIT: if neither corner is a wall and the candidate is not out of bounds, load pos and pulse moved. Otherwise keep pos and pulse blocked. Go to IDLE.
- map_row_addr is 0 outside CHK_A and CHK_B.
- Tick counter:
  - Free-running from reset, counts 0..MOVE_DIV-1 and wraps.
  - Tick pulses for one cycle when the count equals MOVE_DIV-1.
  - A tick while the FSM is not in WAIT_TICK is dropped.

## Timing
- Reset values: pos_x=START_X, pos_y=START_Y, moved=0, blocked=0, busy=0, dir_ready=1, map_row_addr=0, state IDLE, tick counter 0.
- Reset asserted mid-operation aborts the command and does not produce a pulse.
- Latency, with the tick seen in WAIT_TICK at cycle T:
  - CALC at T+1, CHK_A at T+2, CHK_B at T+3, COMMIT at T+4.
  - New pos_x/pos_y and the moved or blocked pulse are visible at T+5, which is also when dir_ready returns to 1.
- An out-of-bounds command reaches COMMIT at T+2, and its outputs are visible at T+3.
- moved and blocked are mutually exclusive and each lasts exactly one cycle.
- At most one command is in flight. dir_valid while busy is not consumed, and the producer must hold it until dir_ready.
- dir is sampled only at the handshake. Later changes have no effect on the command in flight.

## Structure
- The shared params.vh package holds `MAP_WIDTH, the direction encodings (DIR_UP/DOWN/LEFT/RIGHT) and the FSM state encodings.
- A natural sub-module is move_tick_gen, which contains the MOVE_DIV counter and the tick pulse.
- map_horizontal stays outside this block and is instantiated at top level, connected by map_row_addr and map_row_bits.

## Test plan
All scenarios use MOVE_DIV=4 and the default map.
- Open move: reset, then right from (16,16) → corners at col 1, rows 1/1 are clear → moved pulse, pos_x=17, pos_y=16, exactly 5 cycles after the tick.
- Wall ahead: up from (16,16) → ny=15, row 0 is wall → blocked pulse, pos stays (16,16), no moved pulse.
- Inner wall: START=(104,64), right → nx=105, corner x=112 is col 7, row 4 is wall → blocked, pos_x=104.
- Boundary skip: START_X=0, left → out-of-bounds underflow → blocked 3 cycles after the tick, map_row_addr stays 0 throughout.
- Handshake/throttle: dir_valid held high continuously from (16,16) moving down → exactly one move per tick, dir_ready low while busy, pos_y increments 16→17→18 across successive ticks.
- Reset mid-operation: assert reset during CHK_A → next cycle pos=(START_X,START_Y), moved=0, blocked=0, dir_ready=1.
